// File: rtl/screen_capture_writer_pkg.sv
// -----------------------------------------------------------------------------
// screen_capture_writer_pkg
//
// Shared definitions for the screen capture writer and the full-screen drawer:
// screen geometry, capture FSM state encoding, and the layout of a memory word
// (colour in bits [16:8], all other bits zero).
//
// Contents:
//   SCREEN_W / SCREEN_H / SCREEN_PIXELS  screen geometry (160 x 120 = 19200)
//   PIXEL_CNT_W                          width of a 0..SCREEN_PIXELS counter
//   COLOUR_W / COLOUR_LSB / COLOUR_MSB   colour field inside a memory word
//   capture_state_t                      IDLE=0, CAPTURE=1, DRAIN=2, DONE=3
//   in_screen()                          on-screen test for a pixel coordinate
//   colour_word()                        pack a colour into a 32-bit memory word
// -----------------------------------------------------------------------------
package screen_capture_writer_pkg;

    localparam int SCREEN_W      = 160;
    localparam int SCREEN_H      = 120;
    localparam int SCREEN_PIXELS = SCREEN_W * SCREEN_H;
    localparam int PIXEL_CNT_W   = $clog2(SCREEN_PIXELS + 1);

    localparam int X_W           = 8;
    localparam int Y_W           = 7;
    localparam int COLOUR_W      = 9;
    localparam int DATA_W        = 32;
    localparam int COLOUR_LSB    = 8;
    localparam int COLOUR_MSB    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } capture_state_t;

    function automatic logic in_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
    endfunction

    function automatic logic [DATA_W-1:0] colour_word(input logic [COLOUR_W-1:0] colour);
        logic [DATA_W-1:0] word;
        word = '0;
        word[COLOUR_MSB:COLOUR_LSB] = colour;
        return word;
    endfunction

endpackage

// File: rtl/screen_capture_writer_capture_fifo.sv
// -----------------------------------------------------------------------------
// capture_fifo
//
// Small synchronous first-word-fall-through FIFO used as the write buffer of
// the screen capture writer. The head entry is visible on head_data whenever
// empty is low. A push while full is accepted only when a pop happens in the
// same cycle (the freed slot is the one being written).
//
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  number of entries, power of two, >= 2
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high reset, empties the FIFO
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        remove the head entry
//   full       no free entry
//   empty      no valid entry
//   head_data  oldest entry (meaningless while empty)
// -----------------------------------------------------------------------------
module capture_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTR_W:0]     wr_ptr_reg;
    logic [PTR_W:0]     rd_ptr_reg;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]   slot_we;
    logic               pop_ok;
    logic               push_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push_ok && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi));
        end
    endgenerate

    // Storage carries no reset: contents are only observed while non-empty.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                mem[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign head_data = mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/screen_capture_writer.sv
// -----------------------------------------------------------------------------
// screen_capture_writer
//
// Snoops the pixel stream headed for the VGA adapter and writes every plotted,
// on-screen pixel into a 160x120 frame memory (address = y*160 + x, colour in
// word bits [16:8]). Pixels pass through a registered stage and a small FIFO
// that absorbs memory back-pressure; a pixel that finds the FIFO full is lost
// and raises the sticky overflow flag.
//
// Optional build macro: CAPTURE_DROP_COUNT_EN adds output dropCount[15:0], a
// saturating count of out-of-range plus overflow-dropped pixels.
//
// Parameters:
//   FIFO_DEPTH  write-buffer entries (power of two, >= 2)
//   ADDR_W      memory address width (2^ADDR_W >= 19200)
//
// Ports:
//   clock, reset        system clock / synchronous active-high reset
//   iX, iY, iColour     pixel coordinate and colour
//   iPlot               pixel valid
//   captureStart        start pulse, honoured in IDLE only
//   captureStop         stop request, honoured in CAPTURE only
//   memReady            memory accepts a write this cycle
//   oAddress, oData     write address and data (hold while oWren is low)
//   oWren               write strobe; a write completes on oWren & memReady
//   captureBusy         high in CAPTURE or DRAIN
//   captureDone         one-cycle pulse as the FSM returns to IDLE
//   overflow            sticky: an on-screen pixel was lost to a full FIFO
//   dropCount           (CAPTURE_DROP_COUNT_EN only) dropped-pixel counter
// -----------------------------------------------------------------------------
module screen_capture_writer
    import screen_capture_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [X_W-1:0]      iX,
    input  logic [Y_W-1:0]      iY,
    input  logic [COLOUR_W-1:0] iColour,
    input  logic                iPlot,
    input  logic                captureStart,
    input  logic                captureStop,
    input  logic                memReady,
    output logic [ADDR_W-1:0]   oAddress,
    output logic [DATA_W-1:0]   oData,
    output logic                oWren,
    output logic                captureBusy,
    output logic                captureDone,
    output logic                overflow
`ifdef CAPTURE_DROP_COUNT_EN
    ,
    output logic [15:0]         dropCount
`endif
);

    localparam int ENTRY_W = ADDR_W + COLOUR_W;

    capture_state_t        state_reg;
    capture_state_t        state_next;

    logic                  capture_sample;
    logic                  pixel_in_range;
    logic                  start_capture;
    logic [ADDR_W-1:0]     pixel_addr;

    logic                  stage_valid_reg;
    logic [ADDR_W-1:0]     stage_addr_reg;
    logic [COLOUR_W-1:0]   stage_colour_reg;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  stage_drop;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [ADDR_W-1:0]     head_addr;
    logic [COLOUR_W-1:0]   head_colour;

    logic [ADDR_W-1:0]     hold_addr_reg;
    logic [COLOUR_W-1:0]   hold_colour_reg;

    logic [PIXEL_CNT_W-1:0] count_reg;
    logic                   count_full;
    logic                   overflow_reg;

    // ------------------------------------------------------------------
    // Stage 1: sample the snooped pixel while capturing
    // ------------------------------------------------------------------
    assign capture_sample = (state_reg == ST_CAPTURE) && iPlot;
    assign pixel_in_range = in_screen(iX, iY);
    assign start_capture  = (state_reg == ST_IDLE) && captureStart;
    // Computed at full address width so y*160 + x never truncates.
    assign pixel_addr     = ADDR_W'(iY) * ADDR_W'(SCREEN_W) + ADDR_W'(iX);

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_valid_reg  <= 1'b0;
            stage_addr_reg   <= '0;
            stage_colour_reg <= '0;
        end else begin
            stage_valid_reg <= capture_sample && pixel_in_range;
            if (capture_sample) begin
                stage_addr_reg   <= pixel_addr;
                stage_colour_reg <= iColour;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: write buffer
    // ------------------------------------------------------------------
    assign fifo_pop   = !fifo_empty && memReady;
    // A full FIFO still takes the entry when its head leaves this cycle.
    assign fifo_push  = stage_valid_reg && (!fifo_full || fifo_pop);
    assign stage_drop = stage_valid_reg && !fifo_push;

    capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({stage_addr_reg, stage_colour_reg}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    assign head_addr   = fifo_head[ENTRY_W-1:COLOUR_W];
    assign head_colour = fifo_head[COLOUR_W-1:0];

    // The last completed write is remembered so the memory-side outputs stay
    // put while nothing is queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_addr_reg   <= '0;
            hold_colour_reg <= '0;
        end else if (fifo_pop) begin
            hold_addr_reg   <= head_addr;
            hold_colour_reg <= head_colour;
        end
    end

    assign oWren    = !fifo_empty;
    assign oAddress = fifo_empty ? hold_addr_reg : head_addr;
    assign oData    = colour_word(fifo_empty ? hold_colour_reg : head_colour);

    // ------------------------------------------------------------------
    // Completed-write counter (drives the automatic stop)
    // ------------------------------------------------------------------
    assign count_full = (count_reg == PIXEL_CNT_W'(SCREEN_PIXELS));

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (start_capture) begin
            count_reg <= '0;
        end else if (fifo_pop && !count_full) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (start_capture) begin
            overflow_reg <= 1'b0;
        end else if (stage_drop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        captureBusy = 1'b0;
        captureDone = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (captureStart) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                captureBusy = 1'b1;
                // Stop request and a full frame collapse into one transition.
                if (captureStop || count_full) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                captureBusy = 1'b1;
                if (!stage_valid_reg && fifo_empty) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                captureDone = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef CAPTURE_DROP_COUNT_EN
    // ------------------------------------------------------------------
    // Dropped-pixel counter: an off-screen sample and an overflow drop can
    // land in the same cycle, so the increment is up to two.
    // ------------------------------------------------------------------
    logic [15:0] drop_count_reg;
    logic [1:0]  drop_inc;

    assign drop_inc = {1'b0, capture_sample && !pixel_in_range} + {1'b0, stage_drop};

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count_reg <= '0;
        end else if (start_capture) begin
            drop_count_reg <= '0;
        end else if ({1'b0, drop_count_reg} + {15'd0, drop_inc} > 17'h0FFFF) begin
            drop_count_reg <= 16'hFFFF;
        end else begin
            drop_count_reg <= drop_count_reg + {14'd0, drop_inc};
        end
    end

    assign dropCount = drop_count_reg;
`endif

endmodule
